// File: rtl/duty_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : duty_pwm_gen
//  Description : Variable-duty square/PWM generator clocked at the audio
//                sample rate. A phase accumulator advances by freq_word each
//                clock; the top four phase bits are compared against the
//                latched duty (duty_q) to give a high fraction of duty_q/16.
//                duty_q changes only on accumulator wrap, so every period is
//                complete and glitch-free.
//  Config macro: DUTY_SLEW_EN - when defined, duty_q steps by +/-1 toward
//                duty at each wrap instead of jumping straight to it.
//  Ports       :
//    clk          in   sample clock, rising edge
//    reset_n      in   asynchronous active-low reset
//    enable       in   1 = run, 0 = idle (phase cleared, outputs zero)
//    duty         in   4-bit target duty (high fraction = duty/16)
//    freq_word    in   phase increment per clock (0 freezes the phase)
//    pwm_out      out  registered PWM level
//    sample       out  registered signed sample: +AMP / -AMP / 0 when idle
//    period_start out  one-cycle strobe on the first cycle of each period
//  Revision    : 1.0 - initial release
// ============================================================================
module duty_pwm_gen #(
   parameter int                         PHASE_W = 16,
   parameter int                         DATA_W  = 16,
   parameter logic signed [DATA_W-1:0]   AMP     = 16'sd8192
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [3:0]                duty,
   input  logic [PHASE_W-1:0]        freq_word,
   output logic                      pwm_out,
   output logic signed [DATA_W-1:0]  sample,
   output logic                      period_start
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                    r_state;
   logic [PHASE_W-1:0]        r_phase;
   logic [3:0]                r_duty_q;
   // Set on the edge that starts a new period (IDLE->RUN or wrap) so the
   // strobe lines up with the output computed from the period's first phase.
   logic                      r_first;
   logic                      r_pwm;
   logic signed [DATA_W-1:0]  r_sample;
   logic                      r_period_start;

   logic [PHASE_W:0]          w_sum;
   logic                      w_wrap;
   logic                      w_hi;
   logic [3:0]                w_duty_wrap;
   logic signed [DATA_W-1:0]  w_neg_amp;

   // Extra MSB of the sum is the carry out, i.e. the period wrap.
   assign w_sum     = {1'b0, r_phase} + {1'b0, freq_word};
   assign w_wrap    = w_sum[PHASE_W];
   assign w_hi      = (r_phase[PHASE_W-1 -: 4] < r_duty_q);
   assign w_neg_amp = -AMP;

`ifdef DUTY_SLEW_EN
   always_comb begin
      w_duty_wrap = r_duty_q;
      if (r_duty_q < duty) begin
         w_duty_wrap = r_duty_q + 4'd1;
      end else if (r_duty_q > duty) begin
         w_duty_wrap = r_duty_q - 4'd1;
      end
   end
`else
   assign w_duty_wrap = duty;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_phase        <= '0;
         r_duty_q       <= 4'd0;
         r_first        <= 1'b0;
         r_pwm          <= 1'b0;
         r_sample       <= '0;
         r_period_start <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_phase        <= '0;
               r_duty_q       <= duty;
               r_pwm          <= 1'b0;
               r_sample       <= '0;
               r_period_start <= 1'b0;
               r_first        <= enable;
               if (enable) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!enable) begin
                  // Leaving RUN wins over a coincident wrap: no strobe,
                  // duty_q takes the idle-style direct load.
                  r_state        <= S_IDLE;
                  r_phase        <= '0;
                  r_duty_q       <= duty;
                  r_pwm          <= 1'b0;
                  r_sample       <= '0;
                  r_period_start <= 1'b0;
                  r_first        <= 1'b0;
               end else begin
                  r_phase        <= w_sum[PHASE_W-1:0];
                  if (w_wrap) begin
                     r_duty_q <= w_duty_wrap;
                  end
                  r_pwm          <= w_hi;
                  r_sample       <= w_hi ? AMP : w_neg_amp;
                  r_period_start <= r_first;
                  r_first        <= w_wrap;
               end
            end
         endcase
      end
   end

   assign pwm_out      = r_pwm;
   assign sample       = r_sample;
   assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_duty_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_duty_pwm_gen
//  Description : Self-checking bench for duty_pwm_gen (PHASE_W = 8). A
//                reference model pushes expected outputs into a scoreboard
//                queue on every clock; they are popped and compared on the
//                falling edge. Directed checks measure high counts and
//                lengths of whole periods. Honours DUTY_SLEW_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_duty_pwm_gen;

   localparam int PW = 8;
   localparam int DW = 16;

   logic                  clk;
   logic                  reset_n;
   logic                  enable;
   logic [3:0]            duty;
   logic [PW-1:0]         freq_word;
   logic                  pwm_out;
   logic signed [DW-1:0]  sample;
   logic                  period_start;

   int n_vec = 0;
   int n_err = 0;

   duty_pwm_gen #(
      .PHASE_W (PW),
      .DATA_W  (DW),
      .AMP     (16'sd8192)
   ) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .duty         (duty),
      .freq_word    (freq_word),
      .pwm_out      (pwm_out),
      .sample       (sample),
      .period_start (period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic                 pwm;
      logic signed [DW-1:0] smp;
      logic                 ps;
   } exp_t;

   exp_t       sb[$];
   int         m_run;
   logic [7:0] m_phase;
   logic [3:0] m_dq;
   logic       m_first;
   logic [8:0] m_sum;
   logic       m_hi;
   exp_t       m_e;

   function automatic logic [3:0] wrap_duty(input logic [3:0] q, input logic [3:0] d);
`ifdef DUTY_SLEW_EN
      if (q < d) return q + 4'd1;
      else if (q > d) return q - 4'd1;
      else return q;
`else
      return d;
`endif
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_run = 0; m_phase = '0; m_dq = '0; m_first = 1'b0;
         sb.delete();
      end else begin
         m_e = '{pwm: 1'b0, smp: 16'sd0, ps: 1'b0};
         if (m_run == 0) begin
            m_phase = '0; m_dq = duty; m_first = enable;
            if (enable) m_run = 1;
         end else if (!enable) begin
            m_run = 0; m_phase = '0; m_dq = duty; m_first = 1'b0;
         end else begin
            m_hi    = (m_phase[7:4] < m_dq);
            m_e.pwm = m_hi;
            m_e.smp = m_hi ? 16'sd8192 : -16'sd8192;
            m_e.ps  = m_first;
            m_sum   = {1'b0, m_phase} + {1'b0, freq_word};
            m_first = m_sum[8];
            if (m_sum[8]) m_dq = wrap_duty(m_dq, duty);
            m_phase = m_sum[7:0];
         end
         sb.push_back(m_e);
      end
   end

   exp_t c_e;
   always @(negedge clk) begin
      if (reset_n && sb.size() > 0) begin
         c_e = sb.pop_front();
         chk("sb_pwm",    32'(pwm_out),      32'(c_e.pwm));
         chk("sb_sample", 32'(sample),       32'(c_e.smp));
         chk("sb_pstart", 32'(period_start), 32'(c_e.ps));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic sync_ps();
      int n = 0;
      while (period_start !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("sync_timeout", 32'd0, 32'd1);
   endtask

   // Starts on a negedge showing period_start; ends on the next such negedge.
   task automatic measure(input int chg, input logic [3:0] nd, output int highs, output int len);
      highs = 0;
      len   = 0;
      do begin
         if (pwm_out === 1'b1) highs++;
         len++;
         if (len == chg) duty = nd;
         @(negedge clk);
      end while (period_start !== 1'b1 && len < 300);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pwm"}, 32'(pwm_out),      32'd0);
      chk({tag, "_smp"}, 32'(sample),       32'd0);
      chk({tag, "_ps"},  32'(period_start), 32'd0);
   endtask

   int h, l, cnt;
   logic first_pwm;

   initial begin
      reset_n = 1'b0; enable = 1'b0; duty = 4'd4; freq_word = 8'd16;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("idle");

      // Basic PWM: duty 4 at 16 clks per period
      enable = 1'b1;
      sync_ps();
      chk("first_pwm", 32'(pwm_out), 32'd1);
      for (int k = 0; k < 3; k++) begin
         measure(0, 4'd0, h, l);
         chk("basic_highs", 32'(h), 32'd4);
         chk("basic_len",   32'(l), 32'd16);
      end

      // duty 0: transitional period keeps 4, then constant low
      duty = 4'd0;
      measure(0, 4'd0, h, l);
      chk("d0_trans_highs", 32'(h), 32'd4);
`ifdef DUTY_SLEW_EN
      for (int k = 0; k < 4; k++) measure(0, 4'd0, h, l);
`else
      measure(0, 4'd0, h, l);
`endif
      chk("d0_highs", 32'(h), 32'd0);
      chk("d0_len",   32'(l), 32'd16);

      // duty 15
      duty = 4'd15;
`ifdef DUTY_SLEW_EN
      for (int k = 0; k < 15; k++) measure(0, 4'd0, h, l);
`else
      measure(0, 4'd0, h, l);
`endif
      measure(0, 4'd0, h, l);
      chk("d15_highs", 32'(h), 32'd15);
      chk("d15_len",   32'(l), 32'd16);

      // Mid-period change 4 -> 12
      duty = 4'd4;
`ifdef DUTY_SLEW_EN
      for (int k = 0; k < 11; k++) measure(0, 4'd0, h, l);
`else
      measure(0, 4'd0, h, l);
`endif
      measure(5, 4'd12, h, l);
      chk("mid_cur_highs", 32'(h), 32'd4);
`ifdef DUTY_SLEW_EN
      for (int k = 0; k < 8; k++) begin
         measure(0, 4'd0, h, l);
         chk("mid_slew_highs", 32'(h), 32'(5 + k));
      end
`else
      measure(0, 4'd0, h, l);
      chk("mid_next_highs", 32'(h), 32'd12);
`endif

      // Drop enable so it is low on the wrap edge (phase 240)
      repeat (14) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk_zero("coll");
      repeat (3) @(negedge clk);
      chk_zero("coll_idle");
      enable = 1'b1;
      @(negedge clk);
      chk_zero("reen_idle");
      sync_ps();
      measure(0, 4'd0, h, l);
      chk("reen_highs", 32'(h), 32'd12);
      chk("reen_len",   32'(l), 32'd16);

      // Frozen phase
      repeat (3) @(negedge clk);
      freq_word = 8'd0;
      repeat (2) @(negedge clk);
      first_pwm = pwm_out;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (period_start === 1'b1) cnt++;
         if (pwm_out !== first_pwm) cnt += 100;
      end
      chk("frozen_events", 32'(cnt), 32'd0);

      // Wrap nearly every cycle
      freq_word = 8'd255;
      @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (period_start === 1'b1) cnt++;
      end
      chk("ff_wraps_ge39", 32'(cnt >= 39), 32'd1);

      // Asynchronous reset mid-period
      freq_word = 8'd16;
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk_zero("async_rst");
      enable = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk_zero("post_rst");

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
